// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light monitor: phase encodings, default phase
// times and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package light_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_YELLOW = 2'b01,
        PH_GREEN  = 2'b10,
        PH_NONE   = 2'b11
    } phase_t;

    localparam int DEF_RED_TIME    = 10;
    localparam int DEF_YELLOW_TIME = 5;
    localparam int DEF_GREEN_TIME  = 15;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // NONE is a recovery phase; the controller restarts into GREEN from it.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_YELLOW: return PH_RED;
            PH_GREEN:  return PH_YELLOW;
            default:   return PH_GREEN;
        endcase
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit BCD to active-low 7-segment decoder with a blank override.
module seg7_decoder
    import light_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: assign a default first in every always_comb so no path can infer a latch.
        seg = SEG_BLANK;
        if (!blank) seg = seg_pattern(digit);
    end

endmodule

// File: rtl/light_phase_monitor.sv
// Monitors the light controller's state/count_time on each tick, drives lamps and a
// 2-digit scanned countdown. Optional green warning flash: define GREEN_WARN_FLASH_EN.
module light_phase_monitor
    import light_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int RED_TIME    = DEF_RED_TIME,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int GREEN_TIME  = DEF_GREEN_TIME,
    parameter int WARN_LEVEL  = 3
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] state,
    input  logic [3:0] count_time,
    input  logic       err_clr,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       phase_done,
    output logic       err_seq,
    output logic       err_count
);

    localparam logic [3:0] RED_T    = 4'(RED_TIME);
    localparam logic [3:0] YELLOW_T = 4'(YELLOW_TIME);
    localparam logic [3:0] GREEN_T  = 4'(GREEN_TIME);
    localparam int         SCAN_W   = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    phase_t      s_in;
    phase_t      p_state;
    logic [3:0]  p_count;
    logic        valid;
    logic        disp_tens;
    logic [3:0]  disp_ones;
    logic [SCAN_W-1:0] scan_cnt;
    logic        tens_sel;
    logic        scan_en;

    phase_t      exp_state;
    logic [3:0]  exp_count;
    logic        seq_bad;
    logic        cnt_bad;
    logic        check;

    assign s_in  = phase_t'(state);
    assign check = tick && valid;

    // Expected pair: continue the countdown, or at zero move to the next phase and reload.
    always_comb begin
        exp_state = p_state;
        exp_count = p_count - 4'd1;
        if (p_count == 4'd0) begin
            exp_state = next_phase(p_state);
            case (exp_state)
                PH_RED:    exp_count = RED_T;
                PH_YELLOW: exp_count = YELLOW_T;
                default:   exp_count = GREEN_T;
            endcase
        end
        seq_bad = (s_in != exp_state) || ((p_count == 4'd0) && (count_time != exp_count));
        cnt_bad = (p_count != 4'd0) && (s_in == exp_state) && (count_time != exp_count);
    end

`ifdef GREEN_WARN_FLASH_EN
    localparam logic [3:0] WARN_T = 4'(WARN_LEVEL);
    logic warn_active;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
        if (reset) begin
            valid       <= 1'b0;
            p_state     <= PH_RED;
            p_count     <= 4'd0;
            lamp_red    <= 1'b0;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
            disp_tens   <= 1'b0;
            disp_ones   <= 4'd0;
            phase_done  <= 1'b0;
            err_seq     <= 1'b0;
            err_count   <= 1'b0;
`ifdef GREEN_WARN_FLASH_EN
            warn_active <= 1'b0;
`endif
        end else begin
            phase_done <= check && (p_count == 4'd0) && !seq_bad;
            // A violation in the same cycle as err_clr keeps the flag set.
            err_seq    <= (err_seq && !err_clr) || (check && seq_bad);
            err_count  <= (err_count && !err_clr) || (check && cnt_bad);
            if (tick) begin
                valid       <= 1'b1;
                p_state     <= s_in;
                p_count     <= count_time;
                lamp_red    <= (s_in == PH_RED);
                lamp_yellow <= (s_in == PH_YELLOW);
                disp_tens   <= (count_time >= 4'd10);
                disp_ones   <= (count_time >= 4'd10) ? count_time - 4'd10 : count_time;
`ifdef GREEN_WARN_FLASH_EN
                if (s_in == PH_GREEN && count_time <= WARN_T) begin
                    lamp_green  <= warn_active ? !lamp_green : 1'b0;
                    warn_active <= 1'b1;
                end else begin
                    lamp_green  <= (s_in == PH_GREEN);
                    warn_active <= 1'b0;
                end
`else
                lamp_green  <= (s_in == PH_GREEN);
`endif
            end
        end
    end

    // Free-running digit scan, independent of tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            tens_sel <= 1'b0;
            scan_en  <= 1'b0;
        end else begin
            scan_en <= 1'b1;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                tens_sel <= !tens_sel;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    logic [3:0] mux_digit;
    logic       mux_blank;

    always_comb begin
        mux_digit = disp_ones;
        mux_blank = !valid;
        if (tens_sel) begin
            mux_digit = {3'b000, disp_tens};
            mux_blank = !valid || !disp_tens;
        end
    end

    assign an = !scan_en ? 2'b11 : (tens_sel ? 2'b01 : 2'b10);

    seg7_decoder u_seg7_decoder (
        .digit (mux_digit),
        .blank (mux_blank),
        .seg   (seg)
    );

endmodule

// File: tb/tb_light_phase_monitor.sv
// Directed, table-driven bench for light_phase_monitor (SCAN_DIV = 4).
module tb_light_phase_monitor;
    import light_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] state = 2'b00;
    logic [3:0] count_time = 4'd0;
    logic       err_clr = 1'b0;
    logic       lamp_red, lamp_yellow, lamp_green;
    logic [6:0] seg;
    logic [1:0] an;
    logic       phase_done, err_seq, err_count;

    int checks = 0;
    int errors = 0;

    light_phase_monitor #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .state       (state),
        .count_time  (count_time),
        .err_clr     (err_clr),
        .lamp_red    (lamp_red),
        .lamp_yellow (lamp_yellow),
        .lamp_green  (lamp_green),
        .seg         (seg),
        .an          (an),
        .phase_done  (phase_done),
        .err_seq     (err_seq),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] s;
        logic [3:0] c;
        logic       clr;
        logic       red, yellow, green;
        logic       done, eseq, ecnt;
    } vec_t;

    vec_t vecs[$];

`ifdef GREEN_WARN_FLASH_EN
    logic m_green    = 1'b0;
    logic m_was_warn = 1'b0;
`endif

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] s, input logic [3:0] c, input logic clr,
                                input logic done, input logic eseq, input logic ecnt);
        vec_t v;
        v.s = s; v.c = c; v.clr = clr;
        v.red    = (s == PH_RED);
        v.yellow = (s == PH_YELLOW);
        v.green  = (s == PH_GREEN);
        v.done = done; v.eseq = eseq; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef GREEN_WARN_FLASH_EN
        m_green = 1'b0;
        m_was_warn = 1'b0;
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " lamp_red"},    lamp_red,    1'b0);
        check({tag, " lamp_yellow"}, lamp_yellow, 1'b0);
        check({tag, " lamp_green"},  lamp_green,  1'b0);
        check({tag, " seg"},         seg,         7'h7F);
        check({tag, " an"},          an,          2'b11);
        check({tag, " phase_done"},  phase_done,  1'b0);
        check({tag, " err_seq"},     err_seq,     1'b0);
        check({tag, " err_count"},   err_count,   1'b0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic exp_green;
        exp_green = v.green;
`ifdef GREEN_WARN_FLASH_EN
        if (v.s == PH_GREEN && v.c <= 4'd3) begin
            exp_green  = m_was_warn ? ~m_green : 1'b0;
            m_was_warn = 1'b1;
        end else begin
            m_was_warn = 1'b0;
        end
        m_green = exp_green;
`endif
        @(negedge clk);
        tick = 1'b1; state = v.s; count_time = v.c; err_clr = v.clr;
        @(negedge clk);
        tick = 1'b0; err_clr = 1'b0;
        check({tag, " lamp_red"},    lamp_red,    v.red);
        check({tag, " lamp_yellow"}, lamp_yellow, v.yellow);
        check({tag, " lamp_green"},  lamp_green,  exp_green);
        check({tag, " phase_done"},  phase_done,  v.done);
        check({tag, " err_seq"},     err_seq,     v.eseq);
        check({tag, " err_count"},   err_count,   v.ecnt);
        @(negedge clk);
        check({tag, " phase_done end"}, phase_done, 1'b0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("%s v%0d", tag, i));
        vecs.delete();
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        check("an after reset", an, 2'b10);
        check("seg blank before sample", seg, 7'h7F);

        // Full legal cycle: three phase changes, no errors.
        add(PH_GREEN, 4'd15, 0, 0, 0, 0);
        for (int c = 14; c >= 0; c--) add(PH_GREEN, 4'(c), 0, 0, 0, 0);
        for (int c = 5; c >= 0; c--)  add(PH_YELLOW, 4'(c), 0, (c == 5), 0, 0);
        for (int c = 10; c >= 0; c--) add(PH_RED, 4'(c), 0, (c == 10), 0, 0);
        add(PH_GREEN, 4'd15, 0, 1, 0, 0);
        run_table("legal");

        // Countdown error, clear, sequence error, set-wins, NONE recovery.
        do_reset();
        add(PH_GREEN, 4'd7, 0, 0, 0, 0);
        add(PH_GREEN, 4'd5, 0, 0, 0, 1);
        add(PH_GREEN, 4'd4, 0, 0, 0, 1);
        add(PH_GREEN, 4'd3, 1, 0, 0, 0);
        add(PH_GREEN, 4'd2, 0, 0, 0, 0);
        add(PH_GREEN, 4'd1, 0, 0, 0, 0);
        add(PH_GREEN, 4'd0, 0, 0, 0, 0);
        add(PH_YELLOW, 4'd5, 0, 1, 0, 0);
        for (int c = 4; c >= 0; c--) add(PH_YELLOW, 4'(c), 0, 0, 0, 0);
        add(PH_GREEN, 4'd15, 0, 0, 1, 0);
        add(PH_NONE,  4'd0,  1, 0, 1, 0);
        add(PH_GREEN, 4'd15, 1, 1, 0, 0);
        run_table("errs");

        // Reset mid-RED with tick in the same cycle, then an unchecked first sample.
        do_reset();
        add(PH_RED, 4'd10, 0, 0, 0, 0);
        add(PH_RED, 4'd7,  0, 0, 0, 1);
        run_table("pre_rst");
        @(negedge clk);
        reset = 1'b1; tick = 1'b1; state = PH_RED; count_time = 4'd6;
        @(negedge clk);
        check_reset_values("mid_rst");
        reset = 1'b0; tick = 1'b0;
        add(PH_RED, 4'd3, 0, 0, 0, 0);
        add(PH_RED, 4'd5, 0, 0, 0, 1);
        run_table("post_rst");

        // Display scan with count 12, then leading-zero blank with count 7.
        do_reset();
        add(PH_GREEN, 4'd12, 0, 0, 0, 0);
        run_table("disp12");
        begin
            logic [1:0] prev_an;
            int run_len;
            bit seen_edge;
            int edges;
            prev_an = an; run_len = 0; seen_edge = 0; edges = 0;
            for (int i = 0; i < 24; i++) begin
                if (an == 2'b10)      check("seg ones 12", seg, 7'h24);
                else if (an == 2'b01) check("seg tens 12", seg, 7'h79);
                else                  check("an scan value", an, 2'b10);
                if (an != prev_an) begin
                    if (seen_edge) check("scan run length", 8'(run_len), 8'd4);
                    seen_edge = 1; run_len = 1; edges++;
                end else begin
                    run_len++;
                end
                prev_an = an;
                @(negedge clk);
            end
            check("scan edges seen", 8'(edges >= 4), 8'd1);
        end
        add(PH_GREEN, 4'd7, 0, 0, 0, 1);
        run_table("disp7");
        begin
            int n;
            n = 0;
            while (an != 2'b01 && n < 10) begin @(negedge clk); n++; end
            check("wait tens digit", 8'(an), 8'(2'b01));
            check("seg tens blank 7", seg, 7'h7F);
            n = 0;
            while (an != 2'b10 && n < 10) begin @(negedge clk); n++; end
            check("wait ones digit", 8'(an), 8'(2'b10));
            check("seg ones 7", seg, 7'h78);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
